// File: rtl/hash_kv_pkg.sv
// Shared definitions for the hash KV port clients: command/status codes,
// FSM state encodings and the key-to-index fold used by every port.
package hash_kv_pkg;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [1:0] STS_OK        = 2'b00;
  localparam logic [1:0] STS_NOT_FOUND = 2'b01;
  localparam logic [1:0] STS_COLLISION = 2'b10;
  localparam logic [1:0] STS_BAD_OP    = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_RD_ISSUE = 3'd1;
  localparam state_t S_RD_WAIT  = 3'd2;
  localparam state_t S_EVAL     = 3'd3;
  localparam state_t S_WRITE    = 3'd4;
  localparam state_t S_RSP      = 3'd5;

  // Widest key/index any client instance may use; callers zero-extend into these.
  localparam int MAX_KEY_WIDTH   = 64;
  localparam int MAX_INDEX_WIDTH = 32;
  localparam int KEY_SEL_WIDTH   = $clog2(MAX_KEY_WIDTH);
  localparam int IDX_SEL_WIDTH   = $clog2(MAX_INDEX_WIDTH);

  // Fold the low index_width key bits with the top index_width key bits.
  function automatic logic [MAX_INDEX_WIDTH-1:0] hash_fold(
    input logic [MAX_KEY_WIDTH-1:0] key,
    input int                       key_width,
    input int                       index_width
  );
    logic [MAX_INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_INDEX_WIDTH; i++) begin
      if (i < index_width) begin
        idx[IDX_SEL_WIDTH'(i)] = key[KEY_SEL_WIDTH'(i)] ^
                                 key[KEY_SEL_WIDTH'(key_width - index_width + i)];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/hash_kv_client_if.sv
// Command/response and table-port signals of one hash KV client.
// The client itself uses the slave view; whatever drives commands uses master.
interface hash_kv_client_if #(
  parameter int key_width   = 16,
  parameter int value_width = 16,
  parameter int index_width = 8
);
  localparam int data_width = 1 + key_width + value_width;

  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [key_width-1:0]   req_key;
  logic [value_width-1:0] req_val;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_status;
  logic [value_width-1:0] rsp_val;

  logic [index_width-1:0] tbl_addr;
  logic                   tbl_ren;
  logic                   tbl_wen;
  logic [data_width-1:0]  tbl_wdata;
  logic [data_width-1:0]  tbl_rdata;

  modport slave (
    input  req_valid, req_op, req_key, req_val, rsp_ready, tbl_rdata,
    output req_ready, rsp_valid, rsp_status, rsp_val,
           tbl_addr, tbl_ren, tbl_wen, tbl_wdata
  );

  modport master (
    output req_valid, req_op, req_key, req_val, rsp_ready, tbl_rdata,
    input  req_ready, rsp_valid, rsp_status, rsp_val,
           tbl_addr, tbl_ren, tbl_wen, tbl_wdata
  );

endinterface

// File: rtl/hash_index_fold.sv
// Combinational key -> table index fold, shared by all port clients so every
// port maps a given key to the same slot.
module hash_index_fold
  import hash_kv_pkg::*;
#(
  parameter int key_width   = 16,
  parameter int index_width = 8
) (
  input  logic [key_width-1:0]   key,
  output logic [index_width-1:0] idx
);

  assign idx = index_width'(hash_fold(MAX_KEY_WIDTH'(key), key_width, index_width));

endmodule

// File: rtl/hash_kv_client.sv
// Request engine for one port of the multiported hash memory: hashes the key,
// reads the slot, decides lookup/insert/delete outcome, optionally writes back.
module hash_kv_client
  import hash_kv_pkg::*;
#(
  parameter int key_width   = 16,
  parameter int value_width = 16,
  parameter int index_width = 8,
  parameter int rd_lat      = 2
) (
  input  logic             clk,
  input  logic             reset,
  hash_kv_client_if.slave  bus
);

  localparam int cnt_width = (rd_lat > 1) ? $clog2(rd_lat) : 1;

  typedef struct packed {
    logic                   valid;
    logic [key_width-1:0]   key;
    logic [value_width-1:0] value;
  } entry_t;

  state_t                 state;
  logic [1:0]             op_q;
  logic [key_width-1:0]   key_q;
  logic [value_width-1:0] val_q;
  logic [index_width-1:0] addr_q;
  entry_t                 wdata_q;
  logic [1:0]             status_q;
  logic [value_width-1:0] rval_q;
  logic [cnt_width-1:0]   wait_cnt;

  logic [index_width-1:0] req_idx;
  entry_t                 rd_entry;
  logic                   match;

  hash_index_fold #(
    .key_width   (key_width),
    .index_width (index_width)
  ) u_fold (
    .key (bus.req_key),
    .idx (req_idx)
  );

  assign rd_entry = bus.tbl_rdata;
  assign match    = rd_entry.valid && (rd_entry.key == key_q);

  // Strobes decode straight from state so an async reset clears them at once.
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.rsp_valid  = (state == S_RSP);
  assign bus.tbl_ren    = (state == S_RD_ISSUE);
  assign bus.tbl_wen    = (state == S_WRITE);
  assign bus.tbl_addr   = addr_q;
  assign bus.tbl_wdata  = wdata_q;
  assign bus.rsp_status = status_q;
  assign bus.rsp_val    = rval_q;

  // NOTE: every register here is non-blocking so all next-state decisions see
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_LOOKUP;
      key_q    <= '0;
      val_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      status_q <= STS_OK;
      rval_q   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            key_q  <= bus.req_key;
            val_q  <= bus.req_val;
            addr_q <= req_idx;
            if (bus.req_op == OP_RSVD) begin
              status_q <= STS_BAD_OP;
              rval_q   <= '0;
              state    <= S_RSP;
            end else begin
              state <= S_RD_ISSUE;
            end
          end
        end

        S_RD_ISSUE: begin
          if (rd_lat == 1) begin
            state <= S_EVAL;
          end else begin
            wait_cnt <= cnt_width'(rd_lat - 1);
            state    <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (wait_cnt == cnt_width'(1)) state <= S_EVAL;
          else                            wait_cnt <= wait_cnt - cnt_width'(1);
        end

        S_EVAL: begin
          case (op_q)
            OP_LOOKUP: begin
              status_q <= match ? STS_OK : STS_NOT_FOUND;
              rval_q   <= match ? rd_entry.value : '0;
              state    <= S_RSP;
            end
            OP_INSERT: begin
              if (!rd_entry.valid || match) begin
                wdata_q  <= '{valid: 1'b1, key: key_q, value: val_q};
                status_q <= STS_OK;
                rval_q   <= match ? rd_entry.value : '0;
                state    <= S_WRITE;
              end else begin
                status_q <= STS_COLLISION;
                rval_q   <= '0;
                state    <= S_RSP;
              end
            end
            OP_DELETE: begin
              if (match) begin
                wdata_q  <= '0;
                status_q <= STS_OK;
                rval_q   <= rd_entry.value;
                state    <= S_WRITE;
              end else begin
                status_q <= STS_NOT_FOUND;
                rval_q   <= '0;
                state    <= S_RSP;
              end
            end
            default: begin
              status_q <= STS_BAD_OP;
              rval_q   <= '0;
              state    <= S_RSP;
            end
          endcase
        end

        S_WRITE: state <= S_RSP;

        S_RSP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_kv_client.sv
// Scoreboard bench for hash_kv_client: a table model answers reads after rd_lat,
// a reference KV model predicts each response, a monitor checks it on delivery.
module tb_hash_kv_client;
  import hash_kv_pkg::*;

  localparam int KW = 16;
  localparam int VW = 16;
  localparam int IW = 8;
  localparam int RL = 2;
  localparam int DW = 1 + KW + VW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hash_kv_client_if #(.key_width(KW), .value_width(VW), .index_width(IW)) bus ();

  hash_kv_client #(
    .key_width   (KW),
    .value_width (VW),
    .index_width (IW),
    .rd_lat      (RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- table memory model ----------------
  logic [DW-1:0] mem [256] = '{default: '0};
  logic [IW-1:0] pipe_a [RL] = '{default: '0};
  logic          pipe_v [RL] = '{default: 1'b0};
  logic [DW-1:0] junk = '0;
  logic          pre_en = 1'b0;
  logic [IW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en)             mem[pre_addr]     <= pre_data;
    else if (bus.tbl_wen)   mem[bus.tbl_addr] <= bus.tbl_wdata;
    pipe_v[0] <= bus.tbl_ren;
    pipe_a[0] <= bus.tbl_addr;
    for (int i = 1; i < RL; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
    junk <= DW'({$urandom(), $urandom()});
  end

  always_comb bus.tbl_rdata = pipe_v[RL-1] ? mem[pipe_a[RL-1]] : junk;

  // ---------------- reference model ----------------
  typedef struct {
    logic          v;
    logic [KW-1:0] k;
    logic [VW-1:0] val;
  } ent_t;
  ent_t ref_tbl [256];

  typedef struct {
    logic [1:0]    status;
    logic [VW-1:0] val;
    int            lat;
    int            n_ren;
    int            n_wen;
    logic [IW-1:0] idx;
    int            acc_cyc;
  } exp_t;
  exp_t sb [$];

  function automatic logic [IW-1:0] ref_idx(input logic [KW-1:0] key);
    int lo, hi;
    lo = int'(key) % 256;
    hi = int'(key) / 256;
    return 8'(lo ^ hi);
  endfunction

  task automatic predict(input logic [1:0] op, input logic [KW-1:0] key,
                         input logic [VW-1:0] val, output exp_t e);
    ent_t cur;
    bit   hit;
    e.idx   = ref_idx(key);
    cur     = ref_tbl[e.idx];
    hit     = cur.v && (cur.k == key);
    e.n_ren = 1;
    e.n_wen = 0;
    e.val   = '0;
    e.lat   = 2 + RL;
    case (op)
      2'b00: begin
        e.status = hit ? 2'b00 : 2'b01;
        e.val    = hit ? cur.val : '0;
      end
      2'b01: begin
        if (!cur.v || hit) begin
          e.status = 2'b00;
          e.val    = hit ? cur.val : '0;
          e.n_wen  = 1;
          e.lat    = 3 + RL;
          ref_tbl[e.idx] = '{v: 1'b1, k: key, val: val};
        end else begin
          e.status = 2'b10;
        end
      end
      2'b10: begin
        if (hit) begin
          e.status = 2'b00;
          e.val    = cur.val;
          e.n_wen  = 1;
          e.lat    = 3 + RL;
          ref_tbl[e.idx] = '{v: 1'b0, k: '0, val: '0};
        end else begin
          e.status = 2'b01;
        end
      end
      default: begin
        e.status = 2'b11;
        e.n_ren  = 0;
        e.lat    = 1;
      end
    endcase
  endtask

  // ---------------- response backpressure ----------------
  bit bp = 1'b0;
  int stall_req = 0;
  initial begin
    int stall_done = 0;
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid && stall_done < stall_req) begin
        bus.rsp_ready = 1'b0;
        stall_done++;
      end else begin
        bus.rsp_ready = bp ? ($urandom_range(0, 1) == 0) : 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  int            n_ren = 0;
  int            n_wen = 0;
  bit            rsp_seen = 1'b0;
  logic [1:0]    held_status;
  logic [VW-1:0] held_val;
  int            last_pop = -1;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (reset) begin
      n_ren    = 0;
      n_wen    = 0;
      rsp_seen = 1'b0;
    end else begin
      if (bus.tbl_ren) begin
        n_ren++;
        check("ren_wen_excl", bus.tbl_wen, 1'b0);
        check("ren_in_flight", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("ren_addr", bus.tbl_addr, sb[0].idx);
      end
      if (bus.tbl_wen) begin
        n_wen++;
        check("wen_in_flight", sb.size() != 0, 1'b1);
        if (sb.size() != 0) check("wen_addr", bus.tbl_addr, sb[0].idx);
      end
      if (bus.rsp_valid) begin
        check("rsp_req_ready_low", bus.req_ready, 1'b0);
        check("rsp_in_flight", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          if (!rsp_seen) begin
            check("rsp_latency", cyc - sb[0].acc_cyc, sb[0].lat);
            rsp_seen    = 1'b1;
            held_status = bus.rsp_status;
            held_val    = bus.rsp_val;
          end else begin
            check("rsp_status_hold", bus.rsp_status, held_status);
            check("rsp_val_hold", bus.rsp_val, held_val);
          end
          if (bus.rsp_ready) begin
            mon_e = sb.pop_front();
            check("rsp_status", bus.rsp_status, mon_e.status);
            check("rsp_val", bus.rsp_val, mon_e.val);
            check("ren_count", n_ren, mon_e.n_ren);
            check("wen_count", n_wen, mon_e.n_wen);
            check("table_word", mem[mon_e.idx],
                  {ref_tbl[mon_e.idx].v, ref_tbl[mon_e.idx].k, ref_tbl[mon_e.idx].val});
            n_ren    = 0;
            n_wen    = 0;
            rsp_seen = 1'b0;
            last_pop = cyc;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    exp_t e;
    bit   acc = 1'b0;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_val   = val;
    bus.req_valid = 1'b1;
    for (int w = 0; w < 400 && !acc; w++) begin
      @(negedge clk);
      if (bus.req_ready) acc = 1'b1;
    end
    check("accept_timeout", acc, 1'b1);
    if (acc) begin
      predict(op, key, val, e);
      e.acc_cyc = cyc;
      check("accept_after_rsp", cyc > last_pop, 1'b1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_key   = KW'($urandom);
    bus.req_val   = VW'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (sb.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain", sb.size(), 0);
  endtask

  task automatic preload(input int idx, input logic v, input logic [KW-1:0] k, input logic [VW-1:0] val);
    pre_en   = 1'b1;
    pre_addr = IW'(idx);
    pre_data = {v, k, val};
    ref_tbl[idx] = '{v: v, k: k, val: val};
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_tbl_ren"}, bus.tbl_ren, 1'b0);
    check({tag, "_tbl_wen"}, bus.tbl_wen, 1'b0);
    check({tag, "_tbl_addr"}, bus.tbl_addr, '0);
    check({tag, "_tbl_wdata"}, bus.tbl_wdata, '0);
    check({tag, "_rsp_status"}, bus.rsp_status, '0);
    check({tag, "_rsp_val"}, bus.rsp_val, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [KW-1:0] pool [8] = '{16'h1234, 16'h3412, 16'h1235, 16'h0026,
                              16'h2600, 16'hABCD, 16'h00FF, 16'hFF00};

  initial begin
    exp_t e;
    logic [1:0]    op;
    logic [KW-1:0] key;
    for (int i = 0; i < 256; i++) ref_tbl[i] = '{v: 1'b0, k: '0, val: '0};
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_key   = '0;
    bus.req_val   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Insert into empty slot, then lookups hit / miss.
    send(OP_INSERT, 16'h1234, 16'hBEEF);
    send(OP_LOOKUP, 16'h1234, 16'h0000);
    preload(8'h27, 1'b1, 16'h1234, 16'hBEEF);
    wait_idle();
    send(OP_LOOKUP, 16'h1235, 16'h0000);

    // Collision, then overwrite of a matching key.
    send(OP_INSERT, 16'h3412, 16'h7777);
    send(OP_INSERT, 16'h1234, 16'h0001);
    wait_idle();

    // Delete with a match, then delete from an invalid slot.
    preload(8'h26, 1'b1, 16'h1234, 16'hBEEF);
    send(OP_DELETE, 16'h1234, 16'h0000);
    send(OP_DELETE, 16'h1234, 16'h0000);
    wait_idle();

    // Response stall of 3 cycles with the next command already waiting.
    stall_req += 3;
    send(OP_LOOKUP, 16'h1234, 16'h0000);
    send(OP_RSVD, 16'h1234, 16'h5555);
    send(OP_INSERT, 16'h00FF, 16'h4242);
    wait_idle();

    // Async reset while an insert is waiting on its read.
    bus.req_op    = OP_INSERT;
    bus.req_key   = 16'hABCD;
    bus.req_val   = 16'h5555;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("abort_accept_ready", bus.req_ready, 1'b1);
    e = '{status: 2'b00, val: '0, lat: 3 + RL, n_ren: 1, n_wen: 1,
          idx: ref_idx(16'hABCD), acc_cyc: cyc};
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    check_reset_outputs("async_reset");
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_req_ready", bus.req_ready, 1'b1);
    repeat (6) @(negedge clk);
    check("abort_no_write", mem[ref_idx(16'hABCD)], '0);
    @(posedge clk);
    #1;
    send(OP_LOOKUP, 16'hABCD, 16'h0000);
    send(OP_INSERT, 16'hABCD, 16'h1111);
    send(OP_LOOKUP, 16'hABCD, 16'h0000);
    wait_idle();

    // Randomized traffic with random response backpressure.
    bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op  = ($urandom_range(0, 15) == 0) ? OP_RSVD : 2'($urandom_range(0, 2));
      key = ($urandom_range(0, 3) == 0) ? KW'($urandom) : pool[$urandom_range(0, 7)];
      send(op, key, VW'($urandom));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
